// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN car controller that latches floor calls and drives engine/door commands from plant sensors
module elevator_ctrl #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_W = 3,
  parameter int DOOR_HOLD = 20,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] buttons,
  input  logic [1:0]               sensor_door,
  input  logic                     sensor_up,
  input  logic                     sensor_down,
  output logic [1:0]               engine,
  output logic [1:0]               door,
  output logic [FLOOR_W-1:0]       floor,
  output logic [BUTTONS_WIDTH-1:0] requests,
  output logic                     fault
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(DOOR_HOLD + 1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(BUTTONS_WIDTH - 1);
  typedef enum logic [2:0] {INIT, IDLE, MOVE_UP, MOVE_DOWN, OPEN, HOLD, CLOSE, FAULT} state_t;
  state_t state, last_state;
  logic dir_up, prev_up, prev_down, door_closed;
  logic [WD_W-1:0] wd;
  logic [HOLD_W-1:0] hold;
  logic arr_up, arr_dn, moving, above, below, go_up, bad, timed_out;
  logic [FLOOR_W-1:0] fu, fd;
  logic [BUTTONS_WIDTH-1:0] here, req_nx;
  always_comb begin
    arr_up = sensor_up & ~prev_up;
    arr_dn = sensor_down & ~prev_down;
    moving = state == MOVE_UP || state == MOVE_DOWN;
    fu = floor + 1'b1;
    fd = floor - 1'b1;
    here = BUTTONS_WIDTH'(1) << floor;
    // a press at the current floor while closing re-opens the door instead of queuing a call
    req_nx = requests | (buttons & ~(state == CLOSE ? here : '0));
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      above = above | (requests[i] && i > int'(floor));
      below = below | (requests[i] && i < int'(floor));
    end
    go_up = dir_up ? above : !below;
    bad = sensor_door == 2'b11 || (sensor_up && sensor_down) || (!moving && (arr_up || arr_dn))
      || (state == MOVE_UP && (arr_dn || (arr_up && floor == TOP)))
      || (state == MOVE_DOWN && (arr_up || (arr_dn && floor == '0)));
    // state == last_state masks a stale count carried in from an unwatched state
    timed_out = state inside {INIT, MOVE_UP, MOVE_DOWN, OPEN, CLOSE} && state == last_state
      && wd == WD_W'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      last_state <= INIT;
      dir_up <= 1'b1;
      prev_up <= 1'b0;
      prev_down <= 1'b0;
      door_closed <= 1'b0;
      wd <= '0;
      hold <= '0;
      engine <= 2'b00;
      door <= 2'b00;
      floor <= '0;
      requests <= '0;
      fault <= 1'b0;
    end else begin
      prev_up <= sensor_up;
      prev_down <= sensor_down;
      door_closed <= sensor_door == 2'b10;
      last_state <= state;
      requests <= req_nx;
      wd <= (state != last_state || (moving && (arr_up || arr_dn))) ? '0 : wd + 1'b1;
      if (bad || timed_out || state == FAULT) begin
        state <= FAULT;
        engine <= 2'b00;
        door <= 2'b00;
        fault <= 1'b1;
      end else begin
        case (state)
          INIT: begin
            if (door == 2'b10 && sensor_door == 2'b10) begin
              state <= IDLE;
              door <= 2'b00;
            end else door <= 2'b10;
          end
          IDLE: begin
            engine <= 2'b00;
            door <= 2'b00;
            if (requests[floor]) begin
              state <= OPEN;
              door <= 2'b01;
            end else if (door_closed && (above || below)) begin
              dir_up <= go_up;
              state <= go_up ? MOVE_UP : MOVE_DOWN;
              engine <= go_up ? 2'b01 : 2'b10;
            end
          end
          MOVE_UP: begin
            if (arr_up) begin
              floor <= fu;
              if (req_nx[fu] || fu == TOP) begin
                engine <= 2'b00;
                state <= OPEN;
              end
            end
          end
          MOVE_DOWN: begin
            if (arr_dn) begin
              floor <= fd;
              if (req_nx[fd] || fd == '0) begin
                engine <= 2'b00;
                state <= OPEN;
              end
            end
          end
          OPEN: begin
            if (door == 2'b01 && sensor_door == 2'b01) begin
              requests <= req_nx & ~here;
              hold <= HOLD_W'(DOOR_HOLD - 1);
              state <= HOLD;
              door <= 2'b00;
            end else door <= 2'b01;
          end
          HOLD: begin
            if (hold == '0) begin
              state <= CLOSE;
              door <= 2'b10;
            end else hold <= hold - 1'b1;
          end
          CLOSE: begin
            if (buttons[floor]) begin
              state <= OPEN;
              door <= 2'b01;
            end else if (door == 2'b10 && sensor_door == 2'b10) begin
              state <= IDLE;
              door <= 2'b00;
            end else door <= 2'b10;
          end
          default: state <= FAULT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: randomized call sets against a SCAN stop-order model, with a reactive plant and directed fault cases
module tb_elevator_ctrl;
  localparam int DOOR_HOLD = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] buttons = '0;
  logic [1:0] sensor_door = 2'b10;
  logic sensor_up = 1'b0;
  logic sensor_down = 1'b0;
  logic [1:0] engine, door;
  logic [2:0] floor;
  logic [7:0] requests;
  logic fault;
  int checks = 0;
  int errors = 0;
  int mfloor = 0;
  bit mdir = 1'b1;
  int exp_q[$];
  int obs_q[$];
  int flog[$];
  logic [1:0] last_door = 2'b00;
  logic [2:0] last_floor = 3'd0;
  int dt = 2;
  int mt = 3;
  int pulse = 0;
  int hcnt = 0;
  bit hon = 1'b0;
  bit pl_off = 1'b0;
  bit noarr = 1'b0;
  int n;
  logic [7:0] s;
  int e2[3] = '{1, 2, 3};
  int e3[6] = '{4, 5, 4, 3, 2, 1};

  elevator_ctrl #(.BUTTONS_WIDTH(8), .FLOOR_W(3), .DOOR_HOLD(DOOR_HOLD), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .sensor_door(sensor_door),
    .sensor_up(sensor_up), .sensor_down(sensor_down), .engine(engine), .door(door),
    .floor(floor), .requests(requests), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // SCAN stop order for a call set, from the current model floor and direction
  task automatic plan(input logic [7:0] s_in);
    logic [7:0] r;
    bit above, below;
    int nxt;
    r = s_in;
    for (int g = 0; g < 20 && r != 0; g++) begin
      if (r[mfloor]) begin
        exp_q.push_back(mfloor);
        r[mfloor] = 1'b0;
      end else begin
        above = 1'b0;
        below = 1'b0;
        nxt = mfloor;
        for (int i = 0; i < 8; i++) begin
          if (r[i] && i > mfloor) above = 1'b1;
          if (r[i] && i < mfloor) below = 1'b1;
        end
        if (mdir ? !above : !below) mdir = !mdir;
        if (mdir) begin
          for (int i = 7; i > mfloor; i--) if (r[i]) nxt = i;
        end else begin
          for (int i = 0; i < mfloor; i++) if (r[i]) nxt = i;
        end
        mfloor = nxt;
      end
    end
  endtask

  task step;
    @(posedge clk);
    #1;
    check("safe_cmds", int'(engine != 2'b11 && door != 2'b11 && (engine == 2'b00 || sensor_door == 2'b10)), 1);
    if (door == 2'b01 && last_door != 2'b01) obs_q.push_back(int'(floor));
    if (floor != last_floor) flog.push_back(int'(floor));
    if (reset) hon = 1'b0;
    else if (door == 2'b00 && last_door == 2'b01) begin
      hon = 1'b1;
      hcnt = 1;
    end else if (hon) begin
      if (door == 2'b00) hcnt++;
      else begin
        hon = 1'b0;
        check("hold_len", hcnt, DOOR_HOLD);
        check("hold_then_close", int'(door), 2);
      end
    end
    if (!pl_off) begin
      if (door == 2'b01 && sensor_door != 2'b01) begin
        if (dt == 0) begin
          sensor_door = 2'b01;
          dt = $urandom_range(1, 4);
        end else begin
          sensor_door = 2'b00;
          dt--;
        end
      end else if (door == 2'b10 && sensor_door != 2'b10) begin
        if (dt == 0) begin
          sensor_door = 2'b10;
          dt = $urandom_range(1, 4);
        end else begin
          sensor_door = 2'b00;
          dt--;
        end
      end
      if (!noarr) begin
        if (engine == 2'b00) begin
          sensor_up = 1'b0;
          sensor_down = 1'b0;
          pulse = 0;
        end else if (pulse > 0) begin
          pulse--;
          if (pulse == 0) begin
            sensor_up = 1'b0;
            sensor_down = 1'b0;
          end
        end else if (mt == 0) begin
          sensor_up = engine == 2'b01;
          sensor_down = engine == 2'b10;
          pulse = $urandom_range(1, 3);
          mt = $urandom_range(2, 6);
        end else mt--;
      end
    end
    last_door = door;
    last_floor = floor;
  endtask

  task automatic reset_dut;
    reset = 1'b1;
    buttons = '0;
    sensor_up = 1'b0;
    sensor_down = 1'b0;
    sensor_door = 2'b10;
    pl_off = 1'b0;
    repeat (2) step;
    reset = 1'b0;
    noarr = 1'b0;
    mfloor = 0;
    mdir = 1'b1;
    repeat (3) step;
    check("rst_floor", int'(floor), 0);
    check("rst_fault", int'(fault), 0);
  endtask

  task automatic run_sc(input logic [7:0] calls);
    int k;
    obs_q.delete();
    exp_q.delete();
    flog.delete();
    plan(calls);
    buttons = calls;
    step;
    buttons = '0;
    k = 0;
    while (!(engine == 2'b00 && door == 2'b00 && sensor_door == 2'b10 && requests == 8'h00
             && obs_q.size() >= exp_q.size()) && k < 3000) begin
      step;
      k++;
    end
    check("sc_done", int'(k < 3000), 1);
    check("n_stops", obs_q.size(), exp_q.size());
    foreach (exp_q[i]) check("stop_floor", i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
    check("end_floor", int'(floor), mfloor);
    check("req_empty", int'(requests), 0);
  endtask

  initial begin
    repeat (2) step;
    reset = 1'b0;
    check("rst_engine", int'(engine), 0);
    check("rst_door", int'(door), 0);
    check("rst_floor0", int'(floor), 0);
    check("rst_requests", int'(requests), 0);
    check("rst_fault0", int'(fault), 0);
    step;
    check("init_close", int'(door), 2);
    step;
    check("idle_door", int'(door), 0);
    check("idle_engine", int'(engine), 0);
    run_sc(8'h08);
    check("t2_path_len", flog.size(), 3);
    foreach (e2[i]) check("t2_path", i < flog.size() ? flog[i] : -1, e2[i]);
    run_sc(8'h22);
    check("t3_path_len", flog.size(), 6);
    foreach (e3[i]) check("t3_path", i < flog.size() ? flog[i] : -1, e3[i]);
    buttons = 8'(1) << floor;
    step;
    buttons = '0;
    n = 0;
    while (door != 2'b10 && n < 300) begin
      step;
      n++;
    end
    check("t4_close_seen", int'(n < 300), 1);
    buttons = 8'(1) << floor;
    step;
    buttons = '0;
    check("reopen", int'(door), 1);
    n = 0;
    while (!(engine == 2'b00 && door == 2'b00 && sensor_door == 2'b10) && n < 300) begin
      step;
      n++;
    end
    check("t4_idle", int'(n < 300), 1);
    check("no_relatch", int'(requests), 0);
    for (int k = 0; k < 12; k++) begin
      s = 8'($urandom_range(0, 255) & $urandom_range(0, 255)) | (8'd1 << $urandom_range(0, 7));
      run_sc(s);
    end
    pl_off = 1'b1;
    sensor_door = 2'b11;
    step;
    check("door11_fault", int'(fault), 1);
    check("door11_engine", int'(engine), 0);
    reset_dut;
    noarr = 1'b1;
    buttons = 8'h10;
    step;
    buttons = '0;
    n = 0;
    while (engine != 2'b01 && n < 20) begin
      step;
      n++;
    end
    check("wd_start", int'(engine), 1);
    n = 0;
    while (!fault && n < 400) begin
      step;
      n++;
    end
    check("wd_fault", int'(fault), 1);
    check("wd_time", int'(n >= 245 && n <= 270), 1);
    check("wd_engine", int'(engine), 0);
    check("wd_door", int'(door), 0);
    buttons = 8'h01;
    step;
    buttons = '0;
    repeat (30) step;
    check("fault_sticky", int'(fault), 1);
    check("fault_latch", int'(requests), 8'h11);
    check("fault_engine", int'(engine), 0);
    reset_dut;
    noarr = 1'b1;
    buttons = 8'h80;
    step;
    buttons = '0;
    n = 0;
    while (engine != 2'b01 && n < 20) begin
      step;
      n++;
    end
    check("t6_start", int'(engine), 1);
    sensor_up = 1'b1;
    repeat (4) step;
    check("held_level", int'(floor), 1);
    check("still_up", int'(engine), 1);
    check("no_fault_yet", int'(fault), 0);
    sensor_down = 1'b1;
    step;
    check("both_fault", int'(fault), 1);
    check("both_engine", int'(engine), 0);
    reset_dut;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
